// File: rtl/note_lane_drawer.sv
// Note-lane renderer: draws a row of coloured square markers, one pixel per
// clock, into the VGA adapter write port. Colours come from a start-time snapshot.
module note_lane_drawer #(
   parameter int NUM_NOTES = 10,
   parameter int SQ_SIZE   = 4,
   parameter int X_START   = 10,
   parameter int X_PITCH   = 10,
   parameter int Y_ROW     = 112
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic                 start,
   input  logic                 clear,
   input  logic [NUM_NOTES-1:0] red_sequence,
   input  logic [NUM_NOTES-1:0] yellow_sequence,
   output logic                 busy,
   output logic                 done,
   output logic [7:0]           x,
   output logic [6:0]           y,
   output logic [2:0]           colour,
   output logic                 plot
);

   // state  | meaning
   // S_IDLE | waiting for start; a start emits pixel 0 on the same edge
   // S_DRAW | counters hold the pixel just emitted; advance and emit the next
   // S_DONE | one-cycle done pulse, start ignored

   localparam int SQ_W = (SQ_SIZE > 1) ? $clog2(SQ_SIZE) : 1;
   localparam int I_W  = (NUM_NOTES > 1) ? $clog2(NUM_NOTES) : 1;
   localparam logic [SQ_W-1:0] SQ_LAST = SQ_W'(SQ_SIZE - 1);
   localparam logic [I_W-1:0]  I_LAST  = I_W'(NUM_NOTES - 1);

   typedef enum logic [1:0] {S_IDLE, S_DRAW, S_DONE} state_t;

   state_t               state, state_nx;
   logic [SQ_W-1:0]      dx, dx_nx, dy, dy_nx;
   logic [I_W-1:0]       idx, idx_nx;
   logic [NUM_NOTES-1:0] red_l, red_nx, yel_l, yel_nx;
   logic                 clr_l, clr_nx;
   logic                 busy_nx, done_nx, plot_nx, emit;
   logic [7:0]           x_nx;
   logic [6:0]           y_nx;
   logic [2:0]           colour_nx;
   logic                 last_px;

   function automatic logic [2:0] pick_colour(input logic clr, input logic r, input logic yl);
      if (clr)     return 3'b000;
      else if (r)  return 3'b100;
      else if (yl) return 3'b110;
      else         return 3'b000;
   endfunction

   assign last_px = (idx == I_LAST) && (dy == SQ_LAST) && (dx == SQ_LAST);

   always_comb begin
      state_nx  = state;
      dx_nx     = dx;
      dy_nx     = dy;
      idx_nx    = idx;
      red_nx    = red_l;
      yel_nx    = yel_l;
      clr_nx    = clr_l;
      emit      = 1'b0;
      done_nx   = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) begin
               red_nx   = red_sequence;
               yel_nx   = yellow_sequence;
               clr_nx   = clear;
               dx_nx    = '0;
               dy_nx    = '0;
               idx_nx   = '0;
               emit     = 1'b1;
               state_nx = S_DRAW;
            end
         end
         S_DRAW: begin
            if (last_px) begin
               done_nx  = 1'b1;
               state_nx = S_DONE;
            end else begin
               emit = 1'b1;
               if (dx == SQ_LAST) begin
                  dx_nx = '0;
                  if (dy == SQ_LAST) begin
                     dy_nx  = '0;
                     idx_nx = idx + I_W'(1);
                  end else begin
                     dy_nx = dy + SQ_W'(1);
                  end
               end else begin
                  dx_nx = dx + SQ_W'(1);
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase

      plot_nx   = emit;
      busy_nx   = emit;
      x_nx      = x;
      y_nx      = y;
      colour_nx = colour;
      if (emit) begin
         x_nx      = 8'(X_START + int'(idx_nx) * X_PITCH + int'(dx_nx));
         y_nx      = 7'(Y_ROW + int'(dy_nx));
         colour_nx = pick_colour(clr_nx, red_nx[idx_nx], yel_nx[idx_nx]);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= S_IDLE;
         dx     <= '0;
         dy     <= '0;
         idx    <= '0;
         red_l  <= '0;
         yel_l  <= '0;
         clr_l  <= 1'b0;
         busy   <= 1'b0;
         done   <= 1'b0;
         plot   <= 1'b0;
         x      <= '0;
         y      <= '0;
         colour <= '0;
      end else begin
         state  <= state_nx;
         dx     <= dx_nx;
         dy     <= dy_nx;
         idx    <= idx_nx;
         red_l  <= red_nx;
         yel_l  <= yel_nx;
         clr_l  <= clr_nx;
         busy   <= busy_nx;
         done   <= done_nx;
         plot   <= plot_nx;
         x      <= x_nx;
         y      <= y_nx;
         colour <= colour_nx;
      end
   end

endmodule
